// File: rtl/fetch_pc_unit.sv
// Program counter and instruction fetch stage: word fetches over req/ack, valid/ready to decode.
// Optional taken-redirect counter output enabled by defining FETCH_PC_TAKEN_CNT_EN.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  input  logic        br_valid,
  input  logic        isBranch,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  output logic        halted
`ifdef FETCH_PC_TAKEN_CNT_EN
  ,
  output logic [31:0] taken_cnt
`endif
);

  typedef enum logic [2:0] {StIdle, StReq, StHold, StDrain, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        halt_pend_q, halt_pend_d;
  logic        redirect;

  assign redirect = br_valid & isBranch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      instr_q      <= 32'h0;
      pc_out_q     <= RESET_PC;
      halt_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      halt_pend_q  <= halt_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    halt_pend_d  = halt_pend_q;
    unique case (state_q)
      StIdle: begin
        if (halt_req) begin
          state_d = StHalt;
        end else if (redirect) begin
          pc_d = br_target;
        end else if (start) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (imem_ack) begin
          if (halt_req) begin
            state_d = StHalt;
          end else if (redirect) begin
            pc_d = br_target;
          end else begin
            instr_d  = imem_data;
            pc_out_d = pc_q;
            state_d  = StHold;
          end
        end else begin
          if (redirect) begin
            pc_d = br_target;
          end
          // The bus address must stay put until the outstanding ack arrives.
          if (redirect || halt_req) begin
            drain_addr_d = pc_q;
            state_d      = StDrain;
          end
          halt_pend_d = halt_pend_q | halt_req;
        end
      end
      StDrain: begin
        if (redirect) begin
          pc_d = br_target;
        end
        if (imem_ack) begin
          state_d = (halt_pend_q || halt_req) ? StHalt : StReq;
        end else if (halt_req) begin
          halt_pend_d = 1'b1;
        end
      end
      StHold: begin
        if (halt_req) begin
          state_d = StHalt;
        end else if (redirect) begin
          pc_d    = br_target;
          state_d = StReq;
        end else if (instr_ready) begin
          pc_d    = pc_q + PC_STEP;
          state_d = StReq;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    imem_req    = (state_q == StReq) || (state_q == StDrain);
    imem_addr   = (state_q == StDrain) ? drain_addr_q : pc_q;
    instr_valid = (state_q == StHold);
    halted      = (state_q == StHalt);
    instr_out   = instr_q;
    pc_out      = pc_out_q;
  end

`ifdef FETCH_PC_TAKEN_CNT_EN
  logic [31:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    if (redirect && (state_q != StHalt)) begin
      taken_cnt_d = taken_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q <= 32'h0;
    end else begin
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign taken_cnt = taken_cnt_q;
`endif

endmodule
